// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60 with a 2:1 clock enable) and a width helper.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam bit DEF_HSYNC_POL = 1'b0;
  localparam bit DEF_VSYNC_POL = 1'b0;

  // Bits needed to hold 0..n-1; never less than one so a 1-state counter is still legal.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Integer clock-enable divider: en is high one clk cycle out of every DIV.
module clk_en_div
  import vga_timing_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic en
);

  localparam int CW = width_of(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at DIV-1; with DIV=1 the counter sits at 0 and en is constant 1.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) cnt_d = '0;
    else               cnt_d = cnt_q + 1'b1;
  end

  // Divider state, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign en = (cnt_q == LAST);

endmodule

// File: rtl/wrapper_vga_timing.sv
// VGA timing front-end: pixel enable, position counters and registered sync/strobe decode.
module wrapper_vga_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = DEF_HSYNC_POL,
  parameter bit VSYNC_POL = DEF_VSYNC_POL,
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_en,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic          display_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("wrapper_vga_timing: CLK_DIV must be >= 1");
  end
  if (H_SYNC < 1) begin : g_bad_h_sync
    $error("wrapper_vga_timing: H_SYNC must be >= 1");
  end
  if (V_SYNC < 1) begin : g_bad_v_sync
    $error("wrapper_vga_timing: V_SYNC must be >= 1");
  end
  if (H_BACK < 1) begin : g_bad_h_back
    $error("wrapper_vga_timing: H_BACK must be >= 1");
  end
  if (V_BACK < 1) begin : g_bad_v_back
    $error("wrapper_vga_timing: V_BACK must be >= 1");
  end

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP_END   = HW'(H_DISPLAY);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP_END   = VW'(V_DISPLAY);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic          pix_en_w;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic          display_on_q, display_on_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_clk_en_div (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en_w)
  );

  // Advance the raster position on each pixel enable, wrapping column then line.
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (pix_en_w) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) vpos_d = '0;
        else                  vpos_d = vpos_q + 1'b1;
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
  end

  // Decode from the next-state position so registered flags line up with hpos/vpos.
  always_comb begin
    display_on_d  = (hpos_d < H_DISP_END) && (vpos_d < V_DISP_END);
    hsync_d       = ((hpos_d >= H_SYNC_START) && (hpos_d < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((vpos_d >= V_SYNC_START) && (vpos_d < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
    // Strobes only fire on the step into column 0, so they stay one clk wide for any divider.
    line_start_d  = pix_en_w && (hpos_d == '0);
    frame_start_d = pix_en_w && (hpos_d == '0) && (vpos_d == '0);
  end

  // Position and output registers; reset parks in both back porches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      display_on_q  <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_w;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign display_on  = display_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/wrapper_vga_timing.md
# wrapper_vga_timing

Parametrised VGA timing front-end for the 8bitworkshop wrappers: derives a pixel clock-enable from the board clock by an integer ratio and generates hsync/vsync, the pixel position, a display-active flag and per-line/per-frame strobes. It replaces ad-hoc toggle dividers plus hierarchical parameter overrides. Every game/test wrapper instantiates one copy and runs its renderer on `pix_en` instead of a derived clock.

## Interface
- `CLK_DIV`, 2, board clocks per pixel (≥1; 1 = every cycle)
- `H_DISPLAY`, 640, visible pixels per line
- `H_FRONT`, 16, front porch in pixels (≥0)
- `H_SYNC`, 96, hsync width in pixels (≥1)
- `H_BACK`, 48, back porch in pixels (≥1)
- `V_DISPLAY`, 480, visible lines
- `V_FRONT`, 10, front porch in lines (≥0)
- `V_SYNC`, 2, vsync width in lines (≥1)
- `V_BACK`, 33, back porch in lines (≥1)
- `HSYNC_POL`, 0, active level of hsync (0 = active-low)
- `VSYNC_POL`, 0, active level of vsync
- Derived: `H_TOTAL` = sum of H terms, `V_TOTAL` = sum of V terms, `HW` = $clog2(H_TOTAL), `VW` = $clog2(V_TOTAL)

Ports:
- `clk` in 1: board clock. One clock domain only.
- `reset` in 1: asynchronous, active-low.
- `pix_en` out 1: pixel clock-enable, one `clk` cycle wide.
- `hpos` out HW: current column, 0..H_TOTAL-1.
- `vpos` out VW: current line, 0..V_TOTAL-1.
- `display_on` out 1: high when hpos<H_DISPLAY and vpos<V_DISPLAY.
- `hsync` out 1: horizontal sync at HSYNC_POL.
- `vsync` out 1: vertical sync at VSYNC_POL.
- `line_start` out 1: one-`clk` pulse on the first cycle hpos=0 is presented.
- `frame_start` out 1: one-`clk` pulse on the first cycle (hpos,vpos)=(0,0) is presented.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` = (div_cnt==CLK_DIV-1). For CLK_DIV=1, `pix_en` is constant 1.
- On `pix_en`:
  - hpos increments. At H_TOTAL-1 it wraps to 0 and vpos increments.
  - At vpos=V_TOTAL-1 with hpos wrap, vpos wraps to 0.
- Counters hold between `pix_en` pulses.
- Horizontal regions: display [0,H_DISPLAY), front porch, sync [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC), back porch. Vertical regions are identical in form using the V terms.
- hsync, vsync, display_on, line_start and frame_start are registered. They are computed from the next-state counters, so they are always consistent with the hpos/vpos presented in the same cycle. Pins are glitch-free.
- Reset:
  - div_cnt=0, hpos=H_TOTAL-1, vpos=V_TOTAL-1.
  - display_on=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0.
  - These values are self-consistent because the reset position lies in both back porches (H_BACK≥1, V_BACK≥1).
- First `pix_en` after reset release wraps to (0,0) and raises line_start and frame_start.
- Reset asserted mid-frame returns every output to its reset value immediately (asynchronous). No partial frame state survives.
- Elaboration error (`$error` in generate) when CLK_DIV<1, H_SYNC<1, V_SYNC<1, H_BACK<1 or V_BACK<1.

## Timing
- `pix_en` period = CLK_DIV `clk` cycles, duty 1/CLK_DIV.
- hpos/vpos and all registered outputs change only in the cycle after a `pix_en` cycle. Latency from that `pix_en` edge to new values is one `clk`.
- line_start/frame_start are high exactly one `clk` cycle, independent of CLK_DIV.
- Line = H_TOTAL·CLK_DIV clocks. Frame = V_TOTAL·H_TOTAL·CLK_DIV clocks.
- vsync edges coincide with hpos wrap to 0.

## Structure
- Package `vga_timing_pkg`: default 640x480@60 constants (the defaults listed under Interface) and a `clog2`-style width helper used by wrappers.
- Sub-module `clk_en_div` (parameter `DIV`; ports clk, reset, en) holds the divider, reusable for audio/tick enables. Counters and decode stay in the top.

## Test plan
- Defaults, release reset: first `pix_en` 2 clocks after release. Next cycle hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1, hsync=1, vsync=1.
- Defaults, one full line: hsync=0 exactly for hpos 656..751 (192 clocks). display_on falls at hpos=640. line_start period 1600 clocks.
- Defaults, one full frame: vsync=0 for vpos 490..491. frame_start period 840000 clocks. vpos max 524, hpos max 799.
- CLK_DIV=1, HSYNC_POL=1, VSYNC_POL=1, tiny timing (8/1/2/1 × 4/1/1/1): `pix_en` constant 1, hsync=1 for hpos 9..10, frame every 84 clocks.
- CLK_DIV=3: `pix_en` high 1 of 3 cycles. hpos steps every 3 clocks. Strobes stay 1 clock wide.
- Assert reset at hpos=300, vpos=200: outputs immediately at reset values. After release, sequence restarts with frame_start as in the first scenario.
